// File: rtl/hs_ram_access_ctrl.sv
// Arbitrates the game work-RAM port between the CPU and the hiscore engine.
// Freezes the CPU at vertical blank, lets the bus settle, then grants the port.
module hs_ram_access_ctrl #(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int SETTLE      = 4,
    parameter int VBL_TIMEOUT = 1 << 20
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          hs_rd_req,
    input  logic          hs_wr_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    input  logic          hs_we,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_grant,
    input  logic          vblank,
    output logic          cpu_pause_req,
    input  logic          cpu_paused,
    output logic          ram_sel,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    // state     | meaning
    // S_IDLE    | CPU owns the RAM, no request pending
    // S_WAIT_VBL| request seen, waiting for vblank rise or timeout
    // S_PAUSE   | asking the pause block to freeze the CPU
    // S_SETTLE  | CPU frozen, port switched, write held off while the bus settles
    // S_GRANT   | hiscore engine drives the RAM port
    // S_RELEASE | port back to CPU path for one cycle before unfreezing
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VBL,
        S_PAUSE,
        S_SETTLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    localparam logic [20:0] TMO_LAST    = 21'(VBL_TIMEOUT - 1);
    localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE - 1);

    state_t      state, state_nx;
    logic        vbl_q, vbl_qq;
    logic        vbl_rise;
    logic        req;
    logic [20:0] tmo_cnt, tmo_cnt_nx;
    logic [7:0]  settle_cnt, settle_cnt_nx;

    assign req      = hs_rd_req | hs_wr_req;
    assign vbl_rise = vbl_q & ~vbl_qq;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            vbl_q      <= 1'b0;
            vbl_qq     <= 1'b0;
            tmo_cnt    <= '0;
            settle_cnt <= '0;
            hs_rdata   <= '0;
        end else begin
            state      <= state_nx;
            vbl_q      <= vblank;
            vbl_qq     <= vbl_q;
            tmo_cnt    <= tmo_cnt_nx;
            settle_cnt <= settle_cnt_nx;
            if (ram_sel) begin
                hs_rdata <= ram_rdata;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        tmo_cnt_nx    = tmo_cnt;
        settle_cnt_nx = settle_cnt;
        cpu_pause_req = 1'b0;
        ram_sel       = 1'b0;
        hs_grant      = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;
        busy          = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                tmo_cnt_nx = '0;
                if (req) begin
                    state_nx = S_WAIT_VBL;
                end
            end

            S_WAIT_VBL: begin
                if (tmo_cnt != '1) begin
                    tmo_cnt_nx = tmo_cnt + 21'd1;
                end
                // a dropped request outranks a vblank edge seen in the same cycle
                if (!req) begin
                    state_nx = S_IDLE;
                end else if (vbl_rise || (tmo_cnt == TMO_LAST)) begin
                    state_nx = S_PAUSE;
                end
            end

            S_PAUSE: begin
                cpu_pause_req = 1'b1;
                if (!req) begin
                    state_nx = S_RELEASE;
                end else if (cpu_paused) begin
                    state_nx      = S_SETTLE;
                    settle_cnt_nx = SETTLE_LOAD;
                end
            end

            S_SETTLE: begin
                cpu_pause_req = 1'b1;
                ram_sel       = 1'b1;
                ram_addr      = hs_addr;
                ram_wdata     = hs_wdata;
                if (!req) begin
                    state_nx = S_RELEASE;
                end else if (!cpu_paused) begin
                    state_nx = S_PAUSE;
                end else if (settle_cnt == 8'd0) begin
                    state_nx = S_GRANT;
                end else begin
                    settle_cnt_nx = settle_cnt - 8'd1;
                end
            end

            S_GRANT: begin
                cpu_pause_req = 1'b1;
                ram_sel       = 1'b1;
                ram_addr      = hs_addr;
                ram_wdata     = hs_wdata;
                // losing the pause ack must kill the write in the same cycle
                hs_grant      = cpu_paused;
                ram_we        = cpu_paused & hs_we;
                if (!req) begin
                    state_nx = S_RELEASE;
                end else if (!cpu_paused) begin
                    state_nx = S_PAUSE;
                end
            end

            S_RELEASE: begin
                cpu_pause_req = 1'b1;
                state_nx      = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hs_ram_access_ctrl.sv
// Directed bench for hs_ram_access_ctrl with a 1-cycle synchronous RAM model.
// Each task drives one scenario and checks hand-derived cycle timing inline.
module tb_hs_ram_access_ctrl;

    logic        clk_sys   = 1'b0;
    logic        reset     = 1'b1;
    logic        hs_rd_req = 1'b0;
    logic        hs_wr_req = 1'b0;
    logic [15:0] hs_addr   = '0;
    logic [7:0]  hs_wdata  = '0;
    logic        hs_we     = 1'b0;
    logic [7:0]  hs_rdata;
    logic        hs_grant;
    logic        vblank    = 1'b0;
    logic        cpu_pause_req;
    logic        cpu_paused = 1'b0;
    logic        ram_sel;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic        pl_en   = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // {busy, cpu_pause_req, ram_sel, hs_grant, ram_we}
    logic [4:0] ctl;
    assign ctl = {busy, cpu_pause_req, ram_sel, hs_grant, ram_we};

    hs_ram_access_ctrl #(
        .AW(16), .DW(8), .SETTLE(4), .VBL_TIMEOUT(64)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .hs_rd_req    (hs_rd_req),
        .hs_wr_req    (hs_wr_req),
        .hs_addr      (hs_addr),
        .hs_wdata     (hs_wdata),
        .hs_we        (hs_we),
        .hs_rdata     (hs_rdata),
        .hs_grant     (hs_grant),
        .vblank       (vblank),
        .cpu_pause_req(cpu_pause_req),
        .cpu_paused   (cpu_paused),
        .ram_sel      (ram_sel),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        ram_rdata <= mem[ram_addr];
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    task automatic cyc;
        @(posedge clk_sys);
        #2;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        cyc;
        pl_en = 1'b0;
    endtask

    task automatic acquire_grant(output bit ok);
        ok = 1'b0;
        cyc;
        vblank = 1'b1;
        cyc;
        vblank = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc;
            if (cpu_pause_req) cpu_paused = 1'b1;
            if (hs_grant) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc;
        reset = 1'b0;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, 5'b00000);
        end
        n_checks++;
        if (hs_rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected %h", hs_rdata, 8'h00);
        end
        n_checks++;
        if ({ram_addr, ram_wdata} !== 24'h0) begin
            n_fail++; $display("FAIL reset_bus: got %h expected %h", {ram_addr, ram_wdata}, 24'h0);
        end
        cyc;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL idle_hold: got %b expected %b", ctl, 5'b00000);
        end
    endtask

    task automatic test_basic_read;
        int k;
        hs_addr   = 16'h0000;
        hs_rd_req = 1'b1;
        cyc;
        n_checks++;
        if (ctl !== 5'b10000) begin
            n_fail++; $display("FAIL wait_vbl_ctl: got %b expected %b", ctl, 5'b10000);
        end
        repeat (9) cyc;
        vblank = 1'b1;
        cyc;
        vblank = 1'b0;
        n_checks++;
        if (ctl !== 5'b10000) begin
            n_fail++; $display("FAIL pause_too_early: got %b expected %b", ctl, 5'b10000);
        end
        cyc;
        n_checks++;
        if (ctl !== 5'b11000) begin
            n_fail++; $display("FAIL pause_req_2cyc: got %b expected %b", ctl, 5'b11000);
        end
        repeat (3) cyc;
        cpu_paused = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            cyc;
            k++;
            if (k == 1) begin
                n_checks++;
                if (ctl !== 5'b11100) begin
                    n_fail++; $display("FAIL settle_ctl: got %b expected %b", ctl, 5'b11100);
                end
            end
            if (hs_grant) break;
        end
        n_checks++;
        if (k !== 5) begin
            n_fail++; $display("FAIL grant_latency: got %0d expected %0d", k, 5);
        end
        hs_addr = 16'h1234;
        #1;
        n_checks++;
        if ({ctl, ram_addr} !== {5'b11110, 16'h1234}) begin
            n_fail++; $display("FAIL grant_addr: got %b/%h expected %b/%h", ctl, ram_addr, 5'b11110, 16'h1234);
        end
        cyc;
        n_checks++;
        if (hs_rdata !== 8'h11) begin
            n_fail++; $display("FAIL rdata_n1: got %h expected %h", hs_rdata, 8'h11);
        end
        cyc;
        n_checks++;
        if (hs_rdata !== 8'h5A) begin
            n_fail++; $display("FAIL rdata_n2: got %h expected %h", hs_rdata, 8'h5A);
        end
        hs_rd_req = 1'b0;
        cyc;
        n_checks++;
        if (ctl !== 5'b11000) begin
            n_fail++; $display("FAIL read_release: got %b expected %b", ctl, 5'b11000);
        end
        cyc;
        cpu_paused = 1'b0;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL read_idle: got %b expected %b", ctl, 5'b00000);
        end
    endtask

    task automatic test_write_burst;
        bit ok;
        hs_wr_req = 1'b1;
        acquire_grant(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL wr_acquire: got %b expected %b", ok, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            hs_addr  = 16'h8000 + 16'(i);
            hs_wdata = 8'hA0 + 8'(i);
            hs_we    = 1'b1;
            #1;
            n_checks++;
            if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 16'h8000 + 16'(i), 8'hA0 + 8'(i)}) begin
                n_fail++; $display("FAIL wr_bus_%0d: got %b/%h/%h", i, ram_we, ram_addr, ram_wdata);
            end
            cyc;
        end
        hs_we     = 1'b0;
        hs_wr_req = 1'b0;
        cyc;
        n_checks++;
        if (ctl !== 5'b11000) begin
            n_fail++; $display("FAIL wr_release: got %b expected %b", ctl, 5'b11000);
        end
        cyc;
        cpu_paused = 1'b0;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL wr_idle: got %b expected %b", ctl, 5'b00000);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (mem[16'h8000 + 16'(i)] !== 8'hA0 + 8'(i)) begin
                n_fail++; $display("FAIL wr_mem_%0d: got %h expected %h", i, mem[16'h8000 + 16'(i)], 8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_vbl_timeout;
        int k;
        hs_rd_req = 1'b1;
        cyc;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            cyc;
            k++;
            if (cpu_pause_req) break;
        end
        n_checks++;
        if (k !== 64) begin
            n_fail++; $display("FAIL vbl_timeout: got %0d expected %0d", k, 64);
        end
        hs_rd_req = 1'b0;
        cyc;
        cyc;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL timeout_idle: got %b expected %b", ctl, 5'b00000);
        end
    endtask

    task automatic test_abort_before_grant;
        bit bad;
        bad = 1'b0;
        hs_rd_req = 1'b1;
        cyc;
        vblank = 1'b1;
        cyc;
        vblank = 1'b0;
        cyc;
        n_checks++;
        if (ctl !== 5'b11000) begin
            n_fail++; $display("FAIL abort_pause: got %b expected %b", ctl, 5'b11000);
        end
        repeat (3) begin
            cyc;
            if (hs_grant || ram_we) bad = 1'b1;
        end
        hs_rd_req = 1'b0;
        cyc;
        n_checks++;
        if (ctl !== 5'b11000) begin
            n_fail++; $display("FAIL abort_release: got %b expected %b", ctl, 5'b11000);
        end
        cyc;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL abort_idle: got %b expected %b", ctl, 5'b00000);
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_grant: got %b expected %b", bad, 1'b0);
        end
    endtask

    task automatic test_pause_loss;
        bit ok;
        int k;
        hs_wr_req = 1'b1;
        acquire_grant(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL loss_acquire: got %b expected %b", ok, 1'b1);
        end
        hs_addr  = 16'h4000;
        hs_wdata = 8'h77;
        hs_we    = 1'b1;
        #1;
        n_checks++;
        if (ram_we !== 1'b1) begin
            n_fail++; $display("FAIL loss_we_before: got %b expected %b", ram_we, 1'b1);
        end
        cpu_paused = 1'b0;
        #1;
        n_checks++;
        if ({hs_grant, ram_we} !== 2'b00) begin
            n_fail++; $display("FAIL loss_comb: got %b expected %b", {hs_grant, ram_we}, 2'b00);
        end
        cyc;
        n_checks++;
        if (ctl !== 5'b11000) begin
            n_fail++; $display("FAIL loss_to_pause: got %b expected %b", ctl, 5'b11000);
        end
        n_checks++;
        if (mem[16'h4000] !== 8'h00) begin
            n_fail++; $display("FAIL loss_no_write: got %h expected %h", mem[16'h4000], 8'h00);
        end
        cpu_paused = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            cyc;
            k++;
            if (hs_grant) break;
        end
        n_checks++;
        if (k !== 5) begin
            n_fail++; $display("FAIL regrant_latency: got %0d expected %0d", k, 5);
        end
        hs_we     = 1'b0;
        hs_wr_req = 1'b0;
        cyc;
        cyc;
        cpu_paused = 1'b0;
    endtask

    task automatic test_reset_in_grant;
        bit ok;
        hs_rd_req = 1'b1;
        acquire_grant(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL rst_acquire: got %b expected %b", ok, 1'b1);
        end
        hs_addr = 16'h1234;
        cyc;
        cyc;
        n_checks++;
        if (hs_rdata !== 8'h5A) begin
            n_fail++; $display("FAIL rst_rdata_before: got %h expected %h", hs_rdata, 8'h5A);
        end
        reset = 1'b1;
        cyc;
        reset = 1'b0;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL rst_grant_ctl: got %b expected %b", ctl, 5'b00000);
        end
        n_checks++;
        if ({hs_rdata, ram_addr, ram_wdata} !== 32'h0) begin
            n_fail++; $display("FAIL rst_grant_data: got %h expected %h", {hs_rdata, ram_addr, ram_wdata}, 32'h0);
        end
        cyc;
        n_checks++;
        if (ctl !== 5'b10000) begin
            n_fail++; $display("FAIL rst_rearm: got %b expected %b", ctl, 5'b10000);
        end
        hs_rd_req  = 1'b0;
        cpu_paused = 1'b0;
        cyc;
        cyc;
    endtask

    task automatic test_vbl_req_race;
        hs_rd_req = 1'b1;
        cyc;
        vblank = 1'b1;
        cyc;
        hs_rd_req = 1'b0;
        vblank    = 1'b0;
        cyc;
        n_checks++;
        if (ctl !== 5'b00000) begin
            n_fail++; $display("FAIL race_req_wins: got %b expected %b", ctl, 5'b00000);
        end
        cyc;
    endtask

    initial begin
        preload(16'h0000, 8'h11);
        preload(16'h1234, 8'h5A);
        preload(16'h4000, 8'h00);
        test_reset();
        test_basic_read();
        test_write_burst();
        test_vbl_timeout();
        test_abort_before_grant();
        test_pause_loss();
        test_reset_in_grant();
        test_vbl_req_race();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
